rv_hart_sched: RTL and testbench



---
 rtl/rv_sched_pkg.sv | 21 ++
 rtl/rv_hart_sched_if.sv | 36 +++
 rtl/rv_hart_sched_rr_pick.sv | 37 +++
 rtl/rv_hart_sched.sv | 114 +++++++++++
 tb/tb_rv_hart_sched.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rv_sched_pkg.sv
// Shared types and sizing for the barrel-pipeline hart scheduler.
// Slot format {valid, id} matches the hart shift chain registers.
package rv_sched_pkg;

   localparam int NUM_HARTS  = 8;
   localparam int HART_W     = 3;
   localparam int PIPE_DEPTH = 6;
   localparam int COOL_W     = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   typedef struct packed {
      logic              valid;
      logic [HART_W-1:0] id;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, id: '0};

   function automatic logic [HART_W-1:0] next_ptr(input logic [HART_W-1:0] id);
      return (int'(id) == NUM_HARTS - 1) ? '0 : id + 1'b1;
   endfunction

endpackage

// File: rtl/rv_hart_sched_if.sv
// Control/status bundle between the pipeline and the hart scheduler.
// Priority-issue signals exist only when RV_HART_SCHED_PRIO_EN is defined.
interface rv_hart_sched_if;
   import rv_sched_pkg::*;

   logic [NUM_HARTS-1:0] hart_en;
   logic                 stall;
   logic                 sleep_vld;
   logic [HART_W-1:0]    sleep_id;
   logic [NUM_HARTS-1:0] wake;
   slot_t                h_out;
   logic [NUM_HARTS-1:0] active;
`ifdef RV_HART_SCHED_PRIO_EN
   logic                 prio_vld;
   logic [HART_W-1:0]    prio_id;

   modport master (
      output hart_en, stall, sleep_vld, sleep_id, wake, prio_vld, prio_id,
      input  h_out, active
   );
   modport slave (
      input  hart_en, stall, sleep_vld, sleep_id, wake, prio_vld, prio_id,
      output h_out, active
   );
`else
   modport master (
      output hart_en, stall, sleep_vld, sleep_id, wake,
      input  h_out, active
   );
   modport slave (
      input  hart_en, stall, sleep_vld, sleep_id, wake,
      output h_out, active
   );
`endif

endinterface

// File: rtl/rv_hart_sched_rr_pick.sv
// Combinational rotating-priority picker: lowest requesting index at or
// after ptr wins, wrapping N-1 -> 0.
module rv_rr_pick
   import rv_sched_pkg::*;
#(
   parameter int N = NUM_HARTS,
   parameter int W = HART_W
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         grant_vld,
   output logic [W-1:0] grant_id
);

   logic [W-1:0] idx [N];
   logic [N-1:0] rot;

   // rot[k] is the request of hart (ptr + k) mod N
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [W:0] sum;
      assign sum     = {1'b0, ptr} + (W+1)'(gi);
      assign idx[gi] = W'((sum >= (W+1)'(N)) ? sum - (W+1)'(N) : sum);
      assign rot[gi] = req[idx[gi]];
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            grant_vld = 1'b1;
            grant_id  = idx[k];
         end
      end
   end

endmodule

// File: rtl/rv_hart_sched.sv
// Dynamic round-robin hart scheduler with per-hart sleep and pipeline cooldown.
// Optional priority issue is enabled by defining RV_HART_SCHED_PRIO_EN.
module rv_hart_sched
   import rv_sched_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   rv_hart_sched_if.slave bus
);

   logic [NUM_HARTS-1:0] sleeping_reg;
   logic [NUM_HARTS-1:0] sleeping_next;
   logic [NUM_HARTS-1:0] cool_zero;
   logic [NUM_HARTS-1:0] eligible;
   logic [HART_W-1:0]    ptr_reg;
   slot_t                h_out_reg;
   logic [NUM_HARTS-1:0] active_reg;

   logic                 rr_vld;
   logic [HART_W-1:0]    rr_id;
   logic                 issue;
   logic [HART_W-1:0]    issue_id;
   logic                 adv_ptr;

   for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      logic [COOL_W-1:0] cool_reg;

      // Wake beats a same-cycle sleep so a wakeup is never lost
      assign sleeping_next[gi] = bus.wake[gi] ? 1'b0 :
                                 (bus.sleep_vld && bus.sleep_id == HART_W'(gi)) ? 1'b1 :
                                 sleeping_reg[gi];
      assign cool_zero[gi] = (cool_reg == '0);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cool_reg <= '0;
         end else if (issue && issue_id == HART_W'(gi)) begin
            cool_reg <= COOL_W'(PIPE_DEPTH - 1);
         end else if (cool_reg != '0) begin
            cool_reg <= cool_reg - 1'b1;
         end
      end
   end

   assign eligible = bus.hart_en & ~sleeping_reg & cool_zero;

   rv_rr_pick #(.N(NUM_HARTS), .W(HART_W)) u_rr_pick (
      .req       (eligible),
      .ptr       (ptr_reg),
      .grant_vld (rr_vld),
      .grant_id  (rr_id)
   );

`ifdef RV_HART_SCHED_PRIO_EN
   logic                 prio_ok;
   logic [HART_W-1:0]    prio_gid;
   logic [NUM_HARTS-1:0] prio_req;

   // Masking to the requested hart turns the picker into an eligibility test
   assign prio_req = eligible & (NUM_HARTS'(1) << bus.prio_id);

   rv_rr_pick #(.N(NUM_HARTS), .W(HART_W)) u_prio_pick (
      .req       (prio_req),
      .ptr       (bus.prio_id),
      .grant_vld (prio_ok),
      .grant_id  (prio_gid)
   );

   always_comb begin
      issue    = 1'b0;
      issue_id = rr_id;
      adv_ptr  = 1'b0;
      if (!bus.stall) begin
         if (bus.prio_vld && prio_ok) begin
            issue    = 1'b1;
            issue_id = prio_gid;
         end else if (rr_vld) begin
            issue    = 1'b1;
            adv_ptr  = 1'b1;
         end
      end
   end
`else
   always_comb begin
      issue    = !bus.stall && rr_vld;
      issue_id = rr_id;
      adv_ptr  = issue;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_out_reg    <= SLOT_BUBBLE;
         active_reg   <= '0;
         sleeping_reg <= '0;
         ptr_reg      <= '0;
      end else begin
         sleeping_reg <= sleeping_next;
         active_reg   <= bus.hart_en & ~sleeping_next;
         if (issue) begin
            h_out_reg <= '{valid: 1'b1, id: issue_id};
            if (adv_ptr) begin
               ptr_reg <= next_ptr(issue_id);
            end
         end else begin
            h_out_reg <= SLOT_BUBBLE;
         end
      end
   end

   assign bus.h_out  = h_out_reg;
   assign bus.active = active_reg;

endmodule

// File: tb/tb_rv_hart_sched.sv
// Scoreboard bench for rv_hart_sched: directed stimulus pushes expected
// {h_out, active} per clock edge; a negedge monitor pops and compares.
module tb_rv_hart_sched;
   import rv_sched_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rv_hart_sched_if bus ();

   rv_hart_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] h;
      logic [7:0] a;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_txn    = 0;

   logic [3:0] p_sleep  [10] = '{4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h8, 4'h9, 4'hB};
   logic [3:0] p_wake   [8]  = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h8, 4'h9, 4'hA, 4'hB};
   logic [3:0] p_stall  [17] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h0, 4'h0, 4'h0,
                                 4'hD, 4'hE, 4'hF, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
   logic [3:0] p_three  [6]  = '{4'h8, 4'h9, 4'hA, 4'h0, 4'h0, 4'h0};

   // Monitor: one transaction per clock edge that has an expectation queued
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_txn++;
            $display("txn %0d: h_out=%h active=%h (want %h %h)",
                     n_txn, 4'(bus.h_out), bus.active, e.h, e.a);
            n_checks++;
            if (4'(bus.h_out) === e.h) n_pass++;
            else $display("FAIL h_out txn %0d: got %h want %h", n_txn, 4'(bus.h_out), e.h);
            n_checks++;
            if (bus.active === e.a) n_pass++;
            else $display("FAIL active txn %0d: got %h want %h", n_txn, bus.active, e.a);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic cyc(input logic [3:0] h, input logic [7:0] a);
      sb_q.push_back({h, a});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(4'h0, 8'h00);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.hart_en   = 8'hFF;
      bus.stall     = 1'b0;
      bus.sleep_vld = 1'b0;
      bus.sleep_id  = '0;
      bus.wake      = '0;
`ifdef RV_HART_SCHED_PRIO_EN
      bus.prio_vld  = 1'b0;
      bus.prio_id   = '0;
`endif

      // All harts enabled: continuous 0..7 rotation, no bubbles
      do_reset();
      for (int k = 0; k < 16; k++) cyc(4'(8 + k % 8), 8'hFF);

      // Single hart: one issue every PIPE_DEPTH cycles
      do_reset();
      bus.hart_en = 8'h01;
      for (int k = 0; k < 12; k++) cyc((k % 6 == 0) ? 4'h8 : 4'h0, 8'h01);

      // Three harts: cooldown forces three bubbles per round
      do_reset();
      bus.hart_en = 8'h07;
      for (int k = 0; k < 12; k++) cyc(p_three[k % 6], 8'h07);
      bus.hart_en = 8'h00;
      cyc(4'h0, 8'h00);
      cyc(4'h0, 8'h00);

      // Sleep hart 2, then wake it
      do_reset();
      bus.hart_en   = 8'hFF;
      bus.sleep_vld = 1'b1;
      bus.sleep_id  = 3'd2;
      cyc(p_sleep[0], 8'hFB);
      bus.sleep_vld = 1'b0;
      for (int k = 1; k < 10; k++) cyc(p_sleep[k], 8'hFB);
      bus.wake = 8'h04;
      cyc(p_wake[0], 8'hFF);
      bus.wake = 8'h00;
      for (int k = 1; k < 8; k++) cyc(p_wake[k], 8'hFF);

      // Sleep and wake of hart 3 in the same cycle: wake wins
      bus.sleep_vld = 1'b1;
      bus.sleep_id  = 3'd3;
      bus.wake      = 8'h08;
      cyc(4'hC, 8'hFF);
      bus.sleep_vld = 1'b0;
      bus.wake      = 8'h00;
      cyc(4'hD, 8'hFF);

      // Stall for three cycles after hart 4 issues
      do_reset();
      for (int k = 0; k < 5; k++) cyc(p_stall[k], 8'hFF);
      bus.stall = 1'b1;
      for (int k = 5; k < 8; k++) cyc(p_stall[k], 8'hFF);
      bus.stall = 1'b0;
      for (int k = 8; k < 17; k++) cyc(p_stall[k], 8'hFF);

      // One-cycle reset mid-run, then restart from hart 0
      do_reset();
      cyc(4'h8, 8'hFF);
      cyc(4'h9, 8'hFF);

`ifdef RV_HART_SCHED_PRIO_EN
      // Priority issue of hart 6 while ptr=1 leaves ptr at 1
      do_reset();
      cyc(4'h8, 8'hFF);
      bus.prio_vld = 1'b1;
      bus.prio_id  = 3'd6;
      cyc(4'hE, 8'hFF);
      bus.prio_vld = 1'b0;
      cyc(4'h9, 8'hFF);
      cyc(4'hA, 8'hFF);
`endif

      @(negedge clk);
      #1;
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard drain: got %0d left want 0", sb_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
